// File: rtl/cipher_pkg.sv
// Shared types and constants for the serial XOR stream cipher.
package cipher_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ENCRYPT,
    SEND
  } state_t;

  localparam logic MODE_REPEAT = 1'b0;
  localparam logic MODE_ROLL   = 1'b1;

endpackage

// File: rtl/key_schedule.sv
// Per-chunk key derivation: plain key, or key rotated left
// by (chunk index mod KEY_W) in rolling mode.
module key_schedule
  import cipher_pkg::*;
#(
  parameter int KEY_W = 8,
  parameter int IDX_W = 8
) (
  input  logic [KEY_W-1:0] key,
  input  logic [IDX_W-1:0] idx,
  input  logic             mode,
  output logic [KEY_W-1:0] k_i
);

  logic [2*KEY_W-1:0] dbl;
  int unsigned        amt;

  always_comb begin
    amt = 32'(idx) % KEY_W;
    dbl = {key, key} >> (KEY_W - amt);
    k_i = (mode == MODE_ROLL) ? dbl[KEY_W-1:0] : key;
  end

endmodule

// File: rtl/xor_stream_cipher.sv
// Serial-in / serial-out XOR cipher: key and message share
// one line, one KEY_W chunk encrypted per cycle.
module xor_stream_cipher
  import cipher_pkg::*;
#(
  parameter int KEY_W = 8,
  parameter int MSG_W = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic ser_in,
  input  logic key_load,
  input  logic msg_load,
  input  logic mode,
  output logic ser_out,
  output logic out_valid,
  output logic busy,
  output logic key_ready,
  output logic err
);

  localparam int NCHUNK = MSG_W / KEY_W;
  localparam int CNT_W  = $clog2(MSG_W + 1);
  localparam int KCW    = $clog2(KEY_W + 1);

  localparam logic [CNT_W-1:0] MSG_END  = CNT_W'(MSG_W);
  localparam logic [CNT_W-1:0] SEND_END = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] ENC_END  = CNT_W'(NCHUNK - 1);
  localparam logic [KCW-1:0]   KEY_END  = KCW'(KEY_W);

  if (KEY_W < 2 || (MSG_W % KEY_W) != 0) begin : g_bad_params
    $error("xor_stream_cipher: MSG_W must be a multiple of KEY_W >= 2");
  end

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   key_sr;
  logic [KCW-1:0]     key_cnt;
  logic               key_load_q;
  logic [MSG_W-1:0]   ct_sr;
  logic [CNT_W-1:0]   cnt;
  logic               mode_q;

  logic               idle;
  logic               key_shift;
  logic               key_rise;
  logic               msg_start;
  logic               msg_err;
  logic               load_done;
  logic               load_abort;
  logic               enc_last;
  logic               send_last;
  logic [KEY_W-1:0]   chunk;
  logic [KEY_W-1:0]   k_i;

  key_schedule #(
    .KEY_W (KEY_W),
    .IDX_W (CNT_W)
  ) u_key_schedule (
    .key  (key_sr),
    .idx  (cnt),
    .mode (mode_q),
    .k_i  (k_i)
  );

  always_comb begin
    idle       = (state_q == IDLE);
    key_shift  = idle & key_load & ~msg_load;
    key_rise   = key_shift & ~key_load_q;
    msg_start  = idle & msg_load & ~key_load & key_ready;
    msg_err    = idle & msg_load & (key_load | ~key_ready);
    load_done  = (state_q == LOAD) & (cnt == MSG_END);
    load_abort = (state_q == LOAD) & ~load_done & ~msg_load;
    enc_last   = (state_q == ENCRYPT) & (cnt == ENC_END);
    send_last  = (state_q == SEND) & (cnt == SEND_END);
    chunk      = ct_sr[cnt*KEY_W +: KEY_W];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (msg_start) state_d = LOAD;
      LOAD:    if (load_done) state_d = ENCRYPT;
               else if (load_abort) state_d = IDLE;
      ENCRYPT: if (enc_last) state_d = SEND;
      SEND:    if (send_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Key register only moves in IDLE, so it is frozen while busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_sr     <= '0;
      key_cnt    <= '0;
      key_ready  <= 1'b0;
      key_load_q <= 1'b0;
    end else begin
      key_load_q <= key_load;
      if (key_shift) begin
        key_sr <= {key_sr[KEY_W-2:0], ser_in};
        if (key_rise) begin
          key_cnt   <= KCW'(1);
          key_ready <= 1'b0;
        end else if (key_cnt != KEY_END) begin
          key_cnt <= key_cnt + 1'b1;
          if (key_cnt == KEY_END - 1'b1) key_ready <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ct_sr  <= '0;
      cnt    <= '0;
      mode_q <= 1'b0;
      err    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (msg_err) err <= 1'b1;
          if (msg_start) begin
            ct_sr  <= {ct_sr[MSG_W-2:0], ser_in};
            cnt    <= CNT_W'(1);
            mode_q <= mode;
            err    <= 1'b0;
          end
        end
        LOAD: begin
          if (load_done) begin
            cnt <= '0;
          end else if (load_abort) begin
            ct_sr <= '0;
            cnt   <= '0;
            err   <= 1'b1;
          end else begin
            ct_sr <= {ct_sr[MSG_W-2:0], ser_in};
            cnt   <= cnt + 1'b1;
          end
        end
        ENCRYPT: begin
          ct_sr[cnt*KEY_W +: KEY_W] <= chunk ^ k_i;
          cnt <= enc_last ? '0 : cnt + 1'b1;
        end
        SEND: begin
          ct_sr <= {ct_sr[MSG_W-2:0], 1'b0};
          cnt   <= send_last ? '0 : cnt + 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign busy      = ~idle;
  assign out_valid = (state_q == SEND);
  assign ser_out   = out_valid & ct_sr[MSG_W-1];

endmodule

// File: tb/tb_xor_stream_cipher.sv
// Directed bench for xor_stream_cipher: default 8/64 instance
// plus a 16/128 instance for the wide-parameter case.
module tb_xor_stream_cipher;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ser_in = 1'b0, key_load = 1'b0, msg_load = 1'b0, mode = 1'b0;
  logic ser_out, out_valid, busy, key_ready, err;

  logic w_ser_in = 1'b0, w_key_load = 1'b0, w_msg_load = 1'b0;
  logic w_mode = 1'b0;
  logic w_ser_out, w_out_valid, w_busy, w_key_ready, w_err;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  xor_stream_cipher dut (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (ser_in),
    .key_load  (key_load),
    .msg_load  (msg_load),
    .mode      (mode),
    .ser_out   (ser_out),
    .out_valid (out_valid),
    .busy      (busy),
    .key_ready (key_ready),
    .err       (err)
  );

  xor_stream_cipher #(.KEY_W(16), .MSG_W(128)) dut_w (
    .clk       (clk),
    .rst       (rst),
    .ser_in    (w_ser_in),
    .key_load  (w_key_load),
    .msg_load  (w_msg_load),
    .mode      (w_mode),
    .ser_out   (w_ser_out),
    .out_valid (w_out_valid),
    .busy      (w_busy),
    .key_ready (w_key_ready),
    .err       (w_err)
  );

  task automatic load_key(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      key_load = 1'b1;
      ser_in   = v[i];
    end
    @(negedge clk);
    key_load = 1'b0;
    ser_in   = 1'b0;
  endtask

  task automatic load_msg(input logic [63:0] v, input logic m, input int n);
    for (int i = 63; i > 63 - n; i--) begin
      @(negedge clk);
      msg_load = 1'b1;
      mode     = m;
      ser_in   = v[i];
    end
    @(negedge clk);
    msg_load = 1'b0;
    ser_in   = 1'b0;
  endtask

  task automatic capture(input bit poke, output logic [63:0] ct,
                         output int nv, output int lat,
                         output bit kr_drop);
    bit seen;
    ct = '0; nv = 0; lat = 0; seen = 0; kr_drop = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      key_load = 1'b0;
      ser_in   = 1'b0;
      if (!key_ready) kr_drop = 1;
      if (out_valid) begin
        if (!seen) lat = c;
        seen = 1;
        ct = {ct[62:0], ser_out};
        nv++;
        if (poke && nv == 10) begin
          key_load = 1'b1;
          ser_in   = 1'b1;
        end
      end else if (seen) begin
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({ser_out, out_valid, busy, key_ready, err} !== 5'b0)
      $display("FAIL reset_outputs got %b want 00000",
               {ser_out, out_valid, busy, key_ready, err});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_no_key_err();
    bit saw_valid = 0;
    @(negedge clk);
    msg_load = 1'b1;
    ser_in   = 1'b1;
    @(negedge clk);
    msg_load = 1'b0;
    ser_in   = 1'b0;
    checks++;
    if (err !== 1'b1) $display("FAIL nokey_err got %b want 1", err);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL nokey_busy got %b want 0", busy);
    else passed++;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1;
    end
    checks++;
    if (saw_valid !== 1'b0)
      $display("FAIL nokey_no_valid got %b want 0", saw_valid);
    else passed++;
  endtask

  task automatic test_key_shift12();
    load_key(32'hFA5, 12);
    checks++;
    if (key_ready !== 1'b1)
      $display("FAIL key12_ready got %b want 1", key_ready);
    else passed++;
  endtask

  task automatic test_mode0();
    logic [63:0] ct; int nv, lat; bit kd;
    load_msg(64'hA3B1F9D2E7C6A594, 1'b0, 64);
    capture(0, ct, nv, lat, kd);
    checks++;
    if (ct !== 64'h06145C7742630031)
      $display("FAIL mode0_ct got %h want 06145c7742630031", ct);
    else passed++;
    checks++;
    if (nv !== 64) $display("FAIL mode0_valid_len got %0d want 64", nv);
    else passed++;
    checks++;
    if (lat !== 9) $display("FAIL mode0_latency got %0d want 9", lat);
    else passed++;
    checks++;
    if ({busy, ser_out, err} !== 3'b000)
      $display("FAIL mode0_idle_after got %b want 000",
               {busy, ser_out, err});
    else passed++;
  endtask

  task automatic test_mode1_poke();
    logic [63:0] ct; int nv, lat; bit kd;
    load_msg(64'hA3B1F9D2E7C6A594, 1'b1, 64);
    capture(1, ct, nv, lat, kd);
    checks++;
    if (ct !== 64'h71D84D88CA50EE31)
      $display("FAIL mode1_ct got %h want 71d84d88ca50ee31", ct);
    else passed++;
    checks++;
    if (nv !== 64) $display("FAIL mode1_valid_len got %0d want 64", nv);
    else passed++;
  endtask

  task automatic test_back_to_back();
    logic [63:0] ct; int nv, lat; bit kd;
    load_msg(64'h0, 1'b0, 64);
    capture(0, ct, nv, lat, kd);
    checks++;
    if (ct !== 64'hA5A5A5A5A5A5A5A5)
      $display("FAIL b2b_ct got %h want a5a5a5a5a5a5a5a5", ct);
    else passed++;
    checks++;
    if (kd !== 1'b0) $display("FAIL b2b_key_ready_drop got %b want 0", kd);
    else passed++;
  endtask

  task automatic test_abort();
    bit saw_valid = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      msg_load = 1'b1;
      mode     = 1'b0;
      ser_in   = i[0];
    end
    @(negedge clk);
    msg_load = 1'b0;
    ser_in   = 1'b0;
    @(negedge clk);
    checks++;
    if (err !== 1'b1) $display("FAIL abort_err got %b want 1", err);
    else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy);
    else passed++;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1;
    end
    checks++;
    if (saw_valid !== 1'b0)
      $display("FAIL abort_no_valid got %b want 0", saw_valid);
    else passed++;
  endtask

  task automatic test_err_clear();
    logic [63:0] ct; int nv, lat; bit kd;
    load_msg(64'hFFFFFFFFFFFFFFFF, 1'b0, 64);
    checks++;
    if (err !== 1'b0) $display("FAIL errclr_err got %b want 0", err);
    else passed++;
    capture(0, ct, nv, lat, kd);
    checks++;
    if (ct !== 64'h5A5A5A5A5A5A5A5A)
      $display("FAIL errclr_ct got %h want 5a5a5a5a5a5a5a5a", ct);
    else passed++;
  endtask

  task automatic test_rst_mid_send();
    int nv = 0;
    bit saw_valid = 0;
    load_msg(64'hA3B1F9D2E7C6A594, 1'b0, 64);
    for (int c = 0; c < 200 && nv < 20; c++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    checks++;
    if (nv !== 20) $display("FAIL rst_reach_send got %0d want 20", nv);
    else passed++;
    rst = 1'b1;
    #1;
    checks++;
    if ({ser_out, out_valid, busy, key_ready} !== 4'b0)
      $display("FAIL rst_mid_send got %b want 0000",
               {ser_out, out_valid, busy, key_ready});
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    repeat (80) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1;
    end
    checks++;
    if (saw_valid !== 1'b0)
      $display("FAIL rst_no_tail got %b want 0", saw_valid);
    else passed++;
  endtask

  task automatic test_wide();
    logic [15:0]  wk;
    logic [127:0] ct, exp_ct;
    int nv = 0, lat = 0;
    bit seen = 0;
    wk = 16'hBEEF;
    exp_ct = {8{16'hBEEF}};
    ct = '0;
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      w_key_load = 1'b1;
      w_ser_in   = wk[i];
    end
    @(negedge clk);
    w_key_load = 1'b0;
    w_ser_in   = 1'b0;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      w_msg_load = 1'b1;
      w_mode     = 1'b0;
      w_ser_in   = 1'b0;
    end
    @(negedge clk);
    w_msg_load = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (w_out_valid) begin
        if (!seen) lat = c;
        seen = 1;
        ct = {ct[126:0], w_ser_out};
        nv++;
      end else if (seen) begin
        break;
      end
    end
    checks++;
    if (ct !== exp_ct)
      $display("FAIL wide_ct got %h want %h", ct, exp_ct);
    else passed++;
    checks++;
    if (nv !== 128) $display("FAIL wide_valid_len got %0d want 128", nv);
    else passed++;
    checks++;
    if (lat !== 9) $display("FAIL wide_latency got %0d want 9", lat);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_no_key_err();
    test_key_shift12();
    test_mode0();
    test_mode1_poke();
    test_back_to_back();
    test_abort();
    test_err_clear();
    test_rst_mid_send();
    test_wide();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
